// File: rtl/lzc_norm_pipe.sv
// Two-stage elastic leading-zero/one counter with a normalising left shift.
// S1 holds the operand and counts it with a 2-bit-leaf merge tree; S2 holds count, all-same flag and shifted operand.
module lzc_norm_pipe #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    out_cnt_o,
  output logic             out_zero_o,
  output logic [WIDTH-1:0] out_norm_o
);

  logic             s1Valid_q;
  logic [WIDTH-1:0] s1Data_q;
  logic             s1Mode_q;
  logic             s2Valid_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic             s1Adv, s2Adv;
  logic [WIDTH-1:0] countVec;
  logic [CW-1:0]    nodeCnt [WIDTH/2];
  logic             nodeAll [WIDTH/2];

  assign s2Adv      = ~s2Valid_q | out_ready_i;
  assign s1Adv      = ~s1Valid_q | s2Adv;
  assign in_ready_o = s1Adv;

  assign countVec = s1Mode_q ? ~s1Data_q : s1Data_q;

  // Merged in place: node j of each level only reads nodes 2j and 2j+1 of the level below.
  always_comb begin
    for (int j = 0; j < WIDTH / 2; j++) begin
      nodeAll[j] = ~(countVec[2*j+1] | countVec[2*j]);
      nodeCnt[j] = {{(CW-1){1'b0}}, ~countVec[2*j+1]};
    end
    for (int l = 1; l < CW; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        nodeCnt[j] = nodeAll[2*j+1] ? (nodeCnt[2*j] | (CW'(1) << l)) : nodeCnt[2*j+1];
        nodeAll[j] = nodeAll[2*j+1] & nodeAll[2*j];
      end
    end
    zero_d = nodeAll[0];
    cnt_d  = nodeAll[0] ? '0 : nodeCnt[0];
  end

  always_comb begin
    norm_d = s1Data_q;
    for (int k = 0; k < CW; k++) begin
      if (cnt_d[k]) norm_d = norm_d << (1 << k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Mode_q  <= 1'b0;
      s2Valid_q <= 1'b0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      norm_q    <= '0;
    end else begin
      if (s1Adv) s1Valid_q <= in_valid_i;
      if (s1Adv && in_valid_i) begin
        s1Data_q <= in_data_i;
        s1Mode_q <= in_mode_i;
      end
      if (s2Adv) s2Valid_q <= s1Valid_q;
      if (s2Adv && s1Valid_q) begin
        cnt_q  <= cnt_d;
        zero_q <= zero_d;
        norm_q <= norm_d;
      end
    end
  end

  assign out_valid_o = s2Valid_q;
  assign out_cnt_o   = cnt_q;
  assign out_zero_o  = zero_q;
  assign out_norm_o  = norm_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe: WIDTH=32 scoreboard with random traffic and backpressure,
// plus WIDTH=8 (exhaustive) and WIDTH=64 instances checked against the same arithmetic reference model.
module tb_lzc_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inReady, inMode, outValid, outReady, outZero;
  logic [31:0] inData, outNorm;
  logic [4:0]  outCnt;

  logic        inValid8, inReady8, inMode8, outValid8, outReady8, outZero8;
  logic [7:0]  inData8, outNorm8;
  logic [2:0]  outCnt8;
  logic        inValid64, inReady64, inMode64, outValid64, outReady64, outZero64;
  logic [63:0] inData64, outNorm64;
  logic [5:0]  outCnt64;

  int errCount = 0;
  int checkCount = 0;
  int cycleCnt = 0;
  int outCount = 0;
  bit rndReadyEn = 1'b0;

  typedef struct {
    logic [127:0] cnt;
    logic         zero;
    logic [127:0] norm;
  } exp_t;

  exp_t        expQ[$];
  bit          heldValid = 1'b0;
  logic [4:0]  heldCnt;
  logic        heldZero;
  logic [31:0] heldNorm;

  lzc_norm_pipe #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData), .in_mode_i(inMode),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .out_cnt_o(outCnt), .out_zero_o(outZero), .out_norm_o(outNorm)
  );

  lzc_norm_pipe #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(inValid8), .in_ready_o(inReady8), .in_data_i(inData8), .in_mode_i(inMode8),
    .out_valid_o(outValid8), .out_ready_i(outReady8),
    .out_cnt_o(outCnt8), .out_zero_o(outZero8), .out_norm_o(outNorm8)
  );

  lzc_norm_pipe #(.WIDTH(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(inValid64), .in_ready_o(inReady64), .in_data_i(inData64), .in_mode_i(inMode64),
    .out_valid_o(outValid64), .out_ready_i(outReady64),
    .out_cnt_o(outCnt64), .out_zero_o(outZero64), .out_norm_o(outNorm64)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Count the leading bits equal to the mode bit by walking down from the MSB.
  function automatic exp_t refModel(input int w, input logic [127:0] d, input logic mode);
    exp_t r;
    logic [127:0] mask, v;
    int i;
    mask   = (128'd1 << w) - 128'd1;
    v      = (mode ? ~d : d) & mask;
    r.zero = (v == 128'd0);
    r.cnt  = 128'd0;
    if (!r.zero) begin
      i = w - 1;
      while (v[i] == 1'b0) i--;
      r.cnt = 128'(w - 1 - i);
    end
    r.norm = (d << r.cnt) & mask;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic m);
    int guard = 0;
    bit ok;
    inValid = 1'b1;
    inData  = d;
    inMode  = m;
    do begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) checkOutput("inReadyTimeout", 0, 1);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic directedCheck(input string tag, input logic [31:0] d, input logic m,
                               input int eCnt, input logic eZero, input logic [31:0] eNorm);
    outReady = 1'b1;
    applyStimulus(d, m);
    inValid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, outValid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, outValid, 1);
    checkOutput({tag, "_cnt"}, outCnt, eCnt);
    checkOutput({tag, "_zero"}, outZero, eZero);
    checkOutput({tag, "_norm"}, outNorm, eNorm);
    @(posedge clk);
    #1;
  endtask

  task automatic smallStep(input logic [7:0] d8, input logic m8, input logic [63:0] d64, input logic m64);
    exp_t e;
    inValid8 = 1'b1; inData8 = d8; inMode8 = m8;
    inValid64 = 1'b1; inData64 = d64; inMode64 = m64;
    @(posedge clk);
    #1;
    inValid8 = 1'b0;
    inValid64 = 1'b0;
    @(posedge clk);
    #1;
    e = refModel(8, d8, m8);
    checkOutput("w8_valid", outValid8, 1);
    checkOutput("w8_ready", inReady8, 1);
    checkOutput("w8_cnt", outCnt8, e.cnt);
    checkOutput("w8_zero", outZero8, e.zero);
    checkOutput("w8_norm", outNorm8, e.norm);
    e = refModel(64, d64, m64);
    checkOutput("w64_valid", outValid64, 1);
    checkOutput("w64_ready", inReady64, 1);
    checkOutput("w64_cnt", outCnt64, e.cnt);
    checkOutput("w64_zero", outZero64, e.zero);
    checkOutput("w64_norm", outNorm64, e.norm);
  endtask

  // Scoreboard: decisions taken at the falling edge apply to the transfer at the following rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      expQ.delete();
      heldValid = 1'b0;
    end else begin
      exp_t e;
      if (heldValid) begin
        checkOutput("holdValid", outValid, 1);
        checkOutput("holdCnt", outCnt, heldCnt);
        checkOutput("holdZero", outZero, heldZero);
        checkOutput("holdNorm", outNorm, heldNorm);
      end
      checkOutput("inReady", inReady, !(expQ.size() == 2 && !outReady));
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("cnt", outCnt, e.cnt);
          checkOutput("zero", outZero, e.zero);
          checkOutput("norm", outNorm, e.norm);
        end
        outCount++;
      end
      heldValid = outValid && !outReady;
      heldCnt   = outCnt;
      heldZero  = outZero;
      heldNorm  = outNorm;
      if (inValid && inReady) expQ.push_back(refModel(32, inData, inMode));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rndReadyEn) outReady = ($urandom_range(0, 99) >= 30);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int startC, base, guard;
    logic [31:0] rnd;
    logic m;

    rst_n = 1'b1;
    inValid = 1'b0; inData = '0; inMode = 1'b0; outReady = 1'b0;
    inValid8 = 1'b0; inData8 = '0; inMode8 = 1'b0; outReady8 = 1'b1;
    inValid64 = 1'b0; inData64 = '0; inMode64 = 1'b0; outReady64 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstCnt", outCnt, 0);
    checkOutput("rstZero", outZero, 0);
    checkOutput("rstNorm", outNorm, 0);
    checkOutput("rstReady", inReady, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directedCheck("one", 32'h0000_0001, 1'b0, 31, 1'b0, 32'h8000_0000);
    directedCheck("zeros", 32'h0000_0000, 1'b0, 0, 1'b1, 32'h0000_0000);
    directedCheck("ones", 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32'hFFFF_FFFF);
    directedCheck("lead1", 32'hFFF0_1234, 1'b1, 12, 1'b0, 32'h0123_4000);
    directedCheck("msb", 32'h8000_0000, 1'b0, 0, 1'b0, 32'h8000_0000);

    // Walking one, back-to-back: last result must leave 34 edges after the first drive.
    outReady = 1'b1;
    startC = cycleCnt;
    base = outCount;
    for (int i = 0; i < 32; i++) applyStimulus(32'd1 << i, 1'b0);
    inValid = 1'b0;
    guard = 0;
    while (outCount < base + 32 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("streamCycles", cycleCnt - startC, 34);

    rndReadyEn = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        inValid = 1'b0;
        @(posedge clk);
        #1;
      end
      rnd = $urandom >> $urandom_range(0, 32);
      m = 1'($urandom_range(0, 1));
      applyStimulus(m ? ~rnd : rnd, m);
    end
    inValid = 1'b0;
    rndReadyEn = 1'b0;
    outReady = 1'b1;
    waitDrain();

    // Fill both stages, then reset asynchronously between edges.
    outReady = 1'b0;
    applyStimulus(32'h0000_0100, 1'b0);
    applyStimulus(32'h0F00_0000, 1'b1);
    inValid = 1'b0;
    #1;
    checkOutput("fullNotReady", inReady, 0);
    checkOutput("fullValid", outValid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", outValid, 0);
    checkOutput("asyncRstCnt", outCnt, 0);
    checkOutput("asyncRstNorm", outNorm, 0);
    checkOutput("asyncRstReady", inReady, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    outReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("staleOut", outValid, 0);
    end
    @(posedge clk);
    #1;
    directedCheck("postRst", 32'h0000_4000, 1'b0, 17, 1'b0, 32'h8000_0000);

    smallStep(8'h01, 1'b0, 64'h1, 1'b0);
    checkOutput("w8_one_cnt", outCnt8, 7);
    checkOutput("w64_one_cnt", outCnt64, 63);
    checkOutput("w64_one_norm", outNorm64, 64'h8000_0000_0000_0000);
    smallStep(8'hFF, 1'b1, 64'hFFF0_0000_0000_1234, 1'b1);
    checkOutput("w8_ones_zero", outZero8, 1);
    checkOutput("w8_ones_norm", outNorm8, 8'hFF);
    checkOutput("w64_lead1_cnt", outCnt64, 12);
    checkOutput("w64_lead1_norm", outNorm64, 64'h0000_0000_0123_4000);
    smallStep(8'h00, 1'b0, 64'h0, 1'b0);
    checkOutput("w8_zeros_zero", outZero8, 1);
    checkOutput("w64_zeros_zero", outZero64, 1);
    for (int t = 0; t < 512; t++) begin
      logic [63:0] d64;
      logic m64;
      d64 = {$urandom, $urandom} >> $urandom_range(0, 64);
      m64 = 1'($urandom_range(0, 1));
      smallStep(8'(t), t[8], m64 ? ~d64 : d64, m64);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
